fetch_dispatch_fsm: RTL and testbench
=====================================

Name: fetch_dispatch_fsm

Overview:
- Top-level sequencer of the microcontroller: fetches each 16-bit instruction from program memory over the shared bus and latches it into the instruction register (IR).
- Decodes the opcode and presents the IR to the execution FSMs (ALU FSM, transfer FSM), then waits for their done pulse before fetching again.
- Drives the instruction word the ALU FSM decodes; handles NOP, HALT, illegal opcodes and execution watchdog.

Parameters:
- MEM_WAIT, 1, number of mem_rd cycles before IR capture (1..15).
- WDOG_CYCLES, 32, max EXEC cycles without a done pulse before error (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus_in  input  16  shared data bus (program memory read data).
- alu_done  input  1  single-cycle done pulse from ALU FSM.
- xfer_done  input  1  single-cycle done pulse from transfer FSM.
- pc_out_en  output  1  PC drives address bus.
- mar_latch  output  1  memory address register captures address bus.
- mem_rd  output  1  program memory read enable.
- pc_inc  output  1  PC increment (only for opcodes not executed by a unit).
- instruction  output  16  instruction word to execution FSMs.
- halted  output  1  HALT executed.
- error  output  1  watchdog expired.
- illegal  output  1  one-cycle pulse on illegal opcode.
- instr_count  output  16  retired-instruction counter.

Behaviour:
- Reset (async, any state, mid-EXEC included): state FETCH_ADDR, IR=0, all outputs 0, instr_count=0, counters 0.
- Moore outputs decoded from state register; IR and counters registered.
- Opcode classes (IR[15:12]):
  - 1000–1110: ALU.
  - 0001–0011: XFER.
  - 0000: NOP.
  - 1111: HALT.
  - 0100–0111: illegal.
- instruction = IR only in EXEC; 16'h0000 in every other state. This guarantees a non-ALU opcode for at least 4 cycles between instructions, which returns the ALU FSM to its initial state. Back-to-back ALU instructions therefore work.
- States and transitions:
  - FETCH_ADDR (1 cycle): pc_out_en=1, mar_latch=1 -> FETCH_READ.
  - FETCH_READ: mem_rd=1; wait counter counts MEM_WAIT cycles -> FETCH_LATCH.
  - FETCH_LATCH (1 cycle): mem_rd=1; IR <= bus_in at end of cycle -> DECODE.
  - DECODE (1 cycle):
    - ALU/XFER -> EXEC.
    - NOP -> PC_INC.
    - HALT -> HALT.
    - illegal -> PC_INC, with illegal=1 during this DECODE cycle.
  - EXEC: instruction=IR; watchdog counts cycles from EXEC entry.
    - Done -> FETCH_ADDR, instr_count+1. Done means alu_done for ALU class, xfer_done for XFER class. A done from the non-matching unit is ignored.
    - Watchdog reaches WDOG_CYCLES with no matching done -> ERROR. If done arrives in that same cycle, done wins.
    - pc_inc stays 0; the execution unit increments PC itself.
  - PC_INC (1 cycle): pc_inc=1 -> FETCH_ADDR.
    - instr_count+1 for NOP only; illegal opcodes are not counted.
  - HALT: halted=1; terminal until reset; instr_count+1 on entry.
  - ERROR: error=1, instruction=0; terminal until reset.
- instr_count wraps 16'hFFFF -> 0.
- Minimum fetch-to-EXEC latency: 3+MEM_WAIT cycles. With MEM_WAIT=1 that is 4 cycles (FETCH_ADDR, FETCH_READ, FETCH_LATCH, DECODE).
- bus_in is sampled only in FETCH_LATCH; X/garbage elsewhere is harmless.
- Done pulses arriving outside EXEC are ignored.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_NOP=4'b0000, OP_HALT=4'b1111, ALU range 4'b1000–4'b1110, XFER range 4'b0001–4'b0011.
  - State encodings (3-bit): FETCH_ADDR, FETCH_READ, FETCH_LATCH, DECODE, EXEC, PC_INC, HALT, ERROR.
  - Opcode-class function/encoding, shared with execution FSMs.
- Natural sub-module: opcode_classifier (combinational, IR[15:12] -> class), reused by transfer FSM.

Test Plan:
- Reset, memory returns 16'h8001 (ALU) -> IR=16'h8001, instruction=16'h8001 on cycle 5 (MEM_WAIT=1); alu_done after 9 cycles -> FETCH_ADDR next cycle, instruction=0, instr_count=1.
- Two consecutive ALU words 16'h9042, 16'hA0C3 with a real ALU FSM attached -> both complete, instruction=0 for ≥4 cycles between them, instr_count=2.
- Word 16'h0000 then 16'hF000 -> one pc_inc pulse, then halted=1 held for 100 cycles, no further pc_out_en, instr_count=2.
- Word 16'h5123 -> illegal pulse 1 cycle, pc_inc 1 cycle, instr_count unchanged, next fetch starts.
- ALU word with alu_done withheld (WDOG_CYCLES=32) -> error=1 after 32 EXEC cycles, instruction=0; xfer_done pulsed during EXEC does not complete it.
- rst asserted mid-EXEC -> all outputs 0 immediately (asynchronous); after release pc_out_en=1 on the first cycle; MEM_WAIT=3 gives mem_rd high for 4 cycles.

Source files
------------

// File: rtl/fetch_dispatch_fsm_pkg.sv
// Shared definitions for the fetch/dispatch sequencer and the execution FSMs:
// opcode constants, sequencer state encoding and opcode classification.
package fetch_dispatch_fsm_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_HALT    = 4'b1111;
  localparam logic [3:0] OP_ALU_LO  = 4'b1000;
  localparam logic [3:0] OP_ALU_HI  = 4'b1110;
  localparam logic [3:0] OP_XFER_LO = 4'b0001;
  localparam logic [3:0] OP_XFER_HI = 4'b0011;

  typedef enum logic [2:0] {
    ST_FETCH_ADDR  = 3'd0,
    ST_FETCH_READ  = 3'd1,
    ST_FETCH_LATCH = 3'd2,
    ST_DECODE      = 3'd3,
    ST_EXEC        = 3'd4,
    ST_PC_INC      = 3'd5,
    ST_HALT        = 3'd6,
    ST_ERROR       = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_XFER    = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } opclass_t;

  function automatic opclass_t classify(input logic [3:0] op);
    opclass_t c;
    if (op == OP_NOP)                              c = CLS_NOP;
    else if (op == OP_HALT)                        c = CLS_HALT;
    else if (op >= OP_ALU_LO && op <= OP_ALU_HI)   c = CLS_ALU;
    else if (op >= OP_XFER_LO && op <= OP_XFER_HI) c = CLS_XFER;
    else                                           c = CLS_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/fetch_dispatch_fsm_opcode_classifier.sv
// Combinational opcode classifier (IR[15:12] -> class), also used by the
// transfer FSM so both sides agree on which unit owns an opcode.
module opcode_classifier
  import fetch_dispatch_fsm_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic [2:0] o_class
);

  assign o_class = classify(i_opcode);

endmodule

// File: rtl/fetch_dispatch_fsm.sv
// Top-level sequencer: fetches a 16-bit word into IR, dispatches it to the
// ALU or transfer FSM and waits for its done pulse, guarded by a watchdog.
module fetch_dispatch_fsm
  import fetch_dispatch_fsm_pkg::*;
#(
  parameter int MEM_WAIT    = 1,
  parameter int WDOG_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        alu_done,
  input  logic        xfer_done,
  output logic        pc_out_en,
  output logic        mar_latch,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic [15:0] instruction,
  output logic        halted,
  output logic        error,
  output logic        illegal,
  output logic [15:0] instr_count
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [3:0]  r_wait;
  logic [7:0]  r_wdog;
  logic [15:0] r_count;
  logic [2:0]  w_class;
  logic        w_done;
  logic        w_wait_end;
  logic        w_wdog_end;
  logic        w_retire;

  opcode_classifier u_classifier (
    .i_opcode (r_ir[15:12]),
    .o_class  (w_class)
  );

  // Only the unit that owns the opcode may complete it.
  assign w_done     = (w_class == CLS_ALU  && alu_done) ||
                      (w_class == CLS_XFER && xfer_done);
  assign w_wait_end = (r_wait == 4'(MEM_WAIT - 1));
  assign w_wdog_end = (r_wdog == 8'(WDOG_CYCLES - 1));
  assign w_retire   = (r_state == ST_EXEC   && w_done) ||
                      (r_state == ST_PC_INC && w_class == CLS_NOP) ||
                      (r_state == ST_DECODE && w_class == CLS_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH_ADDR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH_ADDR:  w_next = ST_FETCH_READ;
      ST_FETCH_READ:  if (w_wait_end) w_next = ST_FETCH_LATCH;
      ST_FETCH_LATCH: w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_class == CLS_ALU || w_class == CLS_XFER) w_next = ST_EXEC;
        else if (w_class == CLS_HALT)                  w_next = ST_HALT;
        else                                           w_next = ST_PC_INC;
      end
      ST_EXEC: begin
        if (w_done)          w_next = ST_FETCH_ADDR;
        else if (w_wdog_end) w_next = ST_ERROR;
      end
      ST_PC_INC:      w_next = ST_FETCH_ADDR;
      ST_HALT:        w_next = ST_HALT;
      ST_ERROR:       w_next = ST_ERROR;
      default:        w_next = ST_FETCH_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir    <= 16'h0000;
      r_wait  <= 4'd0;
      r_wdog  <= 8'd0;
      r_count <= 16'h0000;
    end else begin
      if (r_state == ST_FETCH_LATCH) r_ir <= bus_in;
      r_wait <= (r_state == ST_FETCH_READ) ? r_wait + 4'd1 : 4'd0;
      r_wdog <= (r_state == ST_EXEC) ? r_wdog + 8'd1 : 8'd0;
      if (w_retire) r_count <= r_count + 16'd1;
    end
  end

  // Outputs are held low while rst is high even though the state already reads FETCH_ADDR.
  always_comb begin
    pc_out_en   = 1'b0;
    mar_latch   = 1'b0;
    mem_rd      = 1'b0;
    pc_inc      = 1'b0;
    instruction = 16'h0000;
    halted      = 1'b0;
    error       = 1'b0;
    illegal     = 1'b0;
    instr_count = r_count;
    if (!rst) begin
      case (r_state)
        ST_FETCH_ADDR: begin
          pc_out_en = 1'b1;
          mar_latch = 1'b1;
        end
        ST_FETCH_READ:  mem_rd = 1'b1;
        ST_FETCH_LATCH: mem_rd = 1'b1;
        ST_DECODE:      illegal = (w_class == CLS_ILLEGAL);
        ST_EXEC:        instruction = r_ir;
        ST_PC_INC:      pc_inc = 1'b1;
        ST_HALT:        halted = 1'b1;
        ST_ERROR:       error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// Table-driven bench for fetch_dispatch_fsm with a scoreboard of expected
// per-instruction observations, plus reset, watchdog and HALT sequences.
module tb_fetch_dispatch_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_in = 16'h0000;
  logic        alu_done = 1'b0;
  logic        xfer_done = 1'b0;
  logic        pc_out_en, mar_latch, mem_rd, pc_inc, halted, error, illegal;
  logic [15:0] instruction, instr_count;
  logic        pc_out_en3, mar_latch3, mem_rd3, pc_inc3, halted3, error3, illegal3;
  logic [15:0] instruction3, instr_count3;

  always #5 clk = ~clk;

  fetch_dispatch_fsm #(.MEM_WAIT(1), .WDOG_CYCLES(32)) u_dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .alu_done(alu_done), .xfer_done(xfer_done),
    .pc_out_en(pc_out_en), .mar_latch(mar_latch), .mem_rd(mem_rd), .pc_inc(pc_inc),
    .instruction(instruction), .halted(halted), .error(error), .illegal(illegal),
    .instr_count(instr_count)
  );

  fetch_dispatch_fsm #(.MEM_WAIT(3), .WDOG_CYCLES(32)) u_dut3 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .alu_done(alu_done), .xfer_done(xfer_done),
    .pc_out_en(pc_out_en3), .mar_latch(mar_latch3), .mem_rd(mem_rd3), .pc_inc(pc_inc3),
    .instruction(instruction3), .halted(halted3), .error(error3), .illegal(illegal3),
    .instr_count(instr_count3)
  );

  // fin: 0 = next fetch started, 1 = halted, 2 = error, 3 = timed out
  typedef struct {
    logic [15:0] word;
    int dsel;
    int ddly;
    int exp_first;
    int exp_exec;
    int exp_ill;
    int exp_pci;
    int exp_delta;
    int exp_fin;
  } vec_t;

  typedef struct {
    int first;
    int exec;
    int ill;
    int pci;
    int fin;
    int count;
    int instr_after;
  } obs_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   model_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_done = 1'b0;
    xfer_done = 1'b0;
    #1;
    chk("reset_outputs", {pc_out_en, mar_latch, mem_rd, pc_inc, instruction,
                          halted, error, illegal, instr_count}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_pc_out_en", pc_out_en, 1);
    chk("release_mar_latch", mar_latch, 1);
    model_cnt = 0;
  endtask

  // Entered in a FETCH_ADDR cycle; observes one instruction until the next fetch, HALT or ERROR.
  task automatic run_instr(input logic [15:0] w, input int dsel, input int ddly, output obs_t o);
    o.first = -1; o.exec = 0; o.ill = 0; o.pci = 0; o.fin = 3;
    bus_in = w;
    for (int n = 0; n < 200; n++) begin
      alu_done = 1'b0;
      xfer_done = 1'b0;
      if (halted) begin o.fin = 1; break; end
      if (error) begin o.fin = 2; break; end
      if (n > 0 && pc_out_en) begin o.fin = 0; break; end
      if (instruction != 16'h0000) begin
        if (o.first < 0) o.first = n;
        o.exec++;
        if (o.exec == ddly) begin
          alu_done = (dsel == 1);
          xfer_done = (dsel == 2);
        end
      end
      if (illegal) o.ill++;
      if (pc_inc) o.pci++;
      @(negedge clk);
    end
    alu_done = 1'b0;
    xfer_done = 1'b0;
    o.count = int'(instr_count);
    o.instr_after = int'(instruction);
  endtask

  task automatic run_and_check(input vec_t v);
    obs_t e, o;
    string tag;
    tag = $sformatf("w%04h", v.word);
    e.first = v.exp_first; e.exec = v.exp_exec; e.ill = v.exp_ill; e.pci = v.exp_pci;
    e.fin = v.exp_fin; e.count = (model_cnt + v.exp_delta) & 16'hFFFF; e.instr_after = 0;
    sb.push_back(e);
    run_instr(v.word, v.dsel, v.ddly, o);
    e = sb.pop_front();
    model_cnt = e.count;
    chk({tag, "_first_exec"}, o.first, e.first);
    chk({tag, "_exec_cycles"}, o.exec, e.exec);
    chk({tag, "_illegal"}, o.ill, e.ill);
    chk({tag, "_pc_inc"}, o.pci, e.pci);
    chk({tag, "_finish"}, o.fin, e.fin);
    chk({tag, "_instr_count"}, o.count, e.count);
    chk({tag, "_instr_after"}, o.instr_after, e.instr_after);
    $display("txn word=%04h dsel=%0d first=%0d exec=%0d ill=%0d pci=%0d fin=%0d cnt=%0d",
             v.word, v.dsel, o.first, o.exec, o.ill, o.pci, o.fin, o.count);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int bad;
    int rdcnt;
    int waited;
    vec_t v;

    //               word      dsel ddly first exec ill pci delta fin
    vecs.push_back('{16'h8001, 1,   9,   4,    9,   0,  0,  1,    0});
    vecs.push_back('{16'h9042, 1,   3,   4,    3,   0,  0,  1,    0});
    vecs.push_back('{16'hA0C3, 1,   1,   4,    1,   0,  0,  1,    0});
    vecs.push_back('{16'hE00F, 1,   2,   4,    2,   0,  0,  1,    0});
    vecs.push_back('{16'h1234, 2,   2,   4,    2,   0,  0,  1,    0});
    vecs.push_back('{16'h3FFF, 2,   4,   4,    4,   0,  0,  1,    0});
    vecs.push_back('{16'h0000, 0,   0,  -1,    0,   0,  1,  1,    0});
    vecs.push_back('{16'h5123, 0,   0,  -1,    0,   1,  1,  0,    0});
    vecs.push_back('{16'h4000, 0,   0,  -1,    0,   1,  1,  0,    0});
    vecs.push_back('{16'h7FFF, 0,   0,  -1,    0,   1,  1,  0,    0});
    vecs.push_back('{16'h8ABC, 1,  32,   4,   32,   0,  0,  1,    0});
    vecs.push_back('{16'h2001, 2,   1,   4,    1,   0,  0,  1,    0});

    do_reset();
    chk("reset_instr_count", instr_count, 0);
    foreach (vecs[i]) run_and_check(vecs[i]);

    // Asynchronous reset in the middle of EXEC, then MEM_WAIT=3 read window.
    bus_in = 16'h8123;
    waited = 0;
    while (instruction == 16'h0000 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    chk("midexec_instruction", instruction, 16'h8123);
    #2 rst = 1'b1;
    #1;
    chk("midexec_async_outputs", {pc_out_en, mar_latch, mem_rd, pc_inc, instruction,
                                  halted, error, illegal, instr_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midexec_release_pc_out_en", pc_out_en, 1);
    rdcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_rd3) rdcnt++;
    end
    chk("memwait3_mem_rd_cycles", rdcnt, 4);
    $display("txn midexec_reset memwait3_rd=%0d", rdcnt);

    // Watchdog: a transfer-unit done does not complete an ALU instruction.
    do_reset();
    v = '{16'h8ABC, 2, 5, 4, 32, 0, 0, 0, 2};
    run_and_check(v);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("error_held", error, 1);
    chk("error_count_held", instr_count, 0);

    // Watchdog: an ALU done does not complete a transfer instruction.
    do_reset();
    v = '{16'h2345, 1, 1, 4, 32, 0, 0, 0, 2};
    run_and_check(v);

    // NOP then HALT; HALT is terminal.
    do_reset();
    v = '{16'h0000, 0, 0, -1, 0, 0, 1, 1, 0};
    run_and_check(v);
    v = '{16'hF000, 0, 0, -1, 0, 0, 0, 1, 1};
    run_and_check(v);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      bus_in = 16'($urandom);
      alu_done = (c % 7 == 0);
      xfer_done = (c % 5 == 0);
      @(negedge clk);
      if (!halted || pc_out_en || mem_rd || pc_inc) bad++;
    end
    alu_done = 1'b0;
    xfer_done = 1'b0;
    chk("halt_hold_violations", bad, 0);
    chk("halt_instr_count", instr_count, 2);
    $display("txn halt_hold violations=%0d cnt=%0d", bad, instr_count);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
